inst_mem_responder: RTL and testbench

Responder end of the instruction-fetch interface. It serves 32-bit instruction reads from a fetch unit using a valid/ready request/response handshake and a configurable access latency. It holds a preloadable 64-bit-wide instruction store mapped at the reset-PC region. It sits between the fetch stage and the simulation/FPGA memory model.

---
 rtl/inst_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_inst_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
//
// Responder end of the instruction-fetch interface. A fetch unit requests a
// 32-bit instruction with a valid/ready handshake. The response appears a
// fixed LATENCY cycles after the request is accepted and is held until the
// fetch unit takes it. Instructions live in a preloadable store of DEPTH
// 64-bit words mapped at byte address BASE. A byte-strobed backdoor write
// port fills the store at any time.
//
// Parameters:
//   DEPTH   - number of 64-bit words in the store (power of 2)
//   BASE    - byte address of word 0
//   LATENCY - cycles from request accept to resp_valid (1..15)
//
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   req_valid/req_ready - request handshake
//   req_addr[63:0]      - byte address of the requested instruction
//   resp_valid/resp_ready - response handshake
//   resp_inst[31:0]     - instruction word (0 on a fault)
//   resp_err            - access fault: out of range or not 4-byte aligned
//   wr_en, wr_addr[63:0], wr_data[63:0], wr_strb[7:0]
//                       - backdoor write; wr_addr[2:0] ignored, out-of-range
//                         writes are dropped
//
// Optional build macro INST_MEM_PERF_EN adds:
//   perf_req_cnt[31:0]   - accepted requests since reset (wraps)
//   perf_stall_cnt[31:0] - cycles with resp_valid=1 and resp_ready=0 (wraps)
// ---------------------------------------------------------------------------
module inst_mem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_strb
`ifdef INST_MEM_PERF_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] LIMIT    = BASE + 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [63:0] addr_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic        data_ok_reg;   // response carries store data (not a fault)
    logic        sel_hi_reg;    // response takes the upper half of the word

    logic             enter_resp;
    logic [63:0]      rd_addr;
    logic             rd_fault;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [63:0]      rd_word;

    // The store is read on the edge that enters RESP. With LATENCY=1 that is
    // the accept edge itself, so the address comes straight from req_addr.
    always_comb begin
        enter_resp = 1'b0;
        if (state_reg == IDLE) begin
            enter_resp = req_valid && (LATENCY == 1);
        end else if (state_reg == BUSY) begin
            enter_resp = (cnt_reg == 4'd1);
        end
        rd_addr  = (state_reg == IDLE) ? req_addr : addr_reg;
        rd_fault = (rd_addr < BASE) || (rd_addr >= LIMIT) || (rd_addr[1:0] != 2'b00);
        rd_idx   = IDX_W'((rd_addr - BASE) >> 3);
        wr_hit   = wr_en && (wr_addr >= BASE) && (wr_addr < LIMIT);
        wr_idx   = IDX_W'((wr_addr - BASE) >> 3);
    end

    // One byte-wide RAM per strobe lane. Read and write share an edge, and the
    // read returns the old contents, so a write landing on the RESP-entry
    // edge is not seen by that response.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (wr_hit && wr_strb[gi]) begin
                    lane_mem[wr_idx] <= wr_data[8*gi +: 8];
                end
                if (enter_resp) begin
                    rd_byte_reg <= lane_mem[rd_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            addr_reg       <= 64'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            data_ok_reg    <= 1'b0;
            sel_hi_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg      <= req_addr;
                        req_ready_reg <= 1'b0;
                        if (LATENCY == 1) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                    end
                end
                RESP: begin
                    // Returning to IDLE here keeps req_ready low during the
                    // handshake cycle, so no request is taken alongside it.
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    req_ready_reg  <= 1'b1;
                    resp_valid_reg <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                resp_err_reg <= rd_fault;
                data_ok_reg  <= !rd_fault;
                sel_hi_reg   <= rd_addr[2];
            end
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    // Gating with data_ok_reg forces 0 on faults and out of reset without
    // needing to clear the RAM read register.
    assign resp_inst  = data_ok_reg ? (sel_hi_reg ? rd_word[63:32] : rd_word[31:0]) : 32'd0;

`ifdef INST_MEM_PERF_EN
    logic [31:0] perf_req_cnt_reg;
    logic [31:0] perf_stall_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_req_cnt_reg   <= 32'd0;
            perf_stall_cnt_reg <= 32'd0;
        end else begin
            if (req_ready_reg && req_valid) begin
                perf_req_cnt_reg <= perf_req_cnt_reg + 32'd1;
            end
            if (resp_valid_reg && !resp_ready) begin
                perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_req_cnt   = perf_req_cnt_reg;
    assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_responder
//
// Drives a LATENCY=2 responder with directed and randomized fetches and
// backdoor writes, and a LATENCY=1 responder for back-to-back throughput.
// Expected responses come from a word-array model of the store: a response
// reflects every write that landed before the RESP-entry edge.
// ---------------------------------------------------------------------------
module tb_inst_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LAT   = 2;
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [63:0] req_addr;
    logic [31:0] resp_inst;
    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1;
    logic [63:0] req_addr1;
    logic [31:0] resp_inst1;
    logic        wr_en;
    logic [63:0] wr_addr, wr_data;
    logic [7:0]  wr_strb;
`ifdef INST_MEM_PERF_EN
    logic [31:0] perf_req_cnt, perf_stall_cnt, perf_req_cnt1, perf_stall_cnt1;
`endif

    always #5 clock = ~clock;

    inst_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_err(resp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
`ifdef INST_MEM_PERF_EN
        , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    inst_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_inst(resp_inst1), .resp_err(resp_err1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
`ifdef INST_MEM_PERF_EN
        , .perf_req_cnt(perf_req_cnt1), .perf_stall_cnt(perf_stall_cnt1)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] mem_model [DEPTH];
    logic [31:0] exp_inst;
    logic        exp_err;
    int          exp_req   = 0;
    int          exp_stall = 0;
    logic [31:0] got_inst;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Response the fetch unit should see for byte address a, given the
    // current contents of the model store.
    function automatic void model_expect(input logic [63:0] a, output logic [31:0] inst,
                                         output logic err);
        logic [63:0] w;
        if (a < BASE || a >= LIMIT || (a % 64'd4) != 64'd0) begin
            err  = 1'b1;
            inst = 32'd0;
        end else begin
            w    = mem_model[int'((a - BASE) / 64'd8)];
            inst = ((a % 64'd8) >= 64'd4) ? w[63:32] : w[31:0];
            err  = 1'b0;
        end
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [63:0] d,
                                        input logic [7:0] s);
        int idx;
        if (a >= BASE && a < LIMIT) begin
            idx = int'((a - BASE) / 64'd8);
            for (int b = 0; b < 8; b++) begin
                if (s[b]) mem_model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    // One clock edge. If snap is set this is the RESP-entry edge of a fetch
    // to address a: the expected response is taken before this edge's write.
    task automatic cycle(input bit snap, input logic [63:0] a);
        @(posedge clock);
        if (snap) model_expect(a, exp_inst, exp_err);
        if (wr_en) model_write(wr_addr, wr_data, wr_strb);
        #1;
    endtask

    // Write drive for cycle c of a fetch: mode 0 none, 1 random, 2 one full
    // word write of wd to wa in cycle 'at'.
    task automatic set_wr(input int c, input int mode, input int at,
                          input logic [63:0] wa, input logic [63:0] wd);
        int r;
        wr_en = 1'b0;
        if (mode == 1) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            r       = int'($urandom_range(0, 9));
            if (r == 0)      wr_addr = LIMIT + 64'($urandom_range(0, 15)) * 64'd8;
            else if (r == 1) wr_addr = BASE - 64'd8;
            else             wr_addr = BASE + 64'($urandom_range(0, 15)) * 64'd8
                                            + 64'($urandom_range(0, 7));
            wr_data = {$urandom, $urandom};
            wr_strb = 8'($urandom);
        end else if (mode == 2 && c == at) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
            wr_strb = 8'hFF;
        end
    endtask

    task automatic read_txn(input logic [63:0] a, input int stall, input int mode,
                            input int at, input logic [63:0] wa, input logic [63:0] wd,
                            output logic [31:0] got);
        int c = 0;
        got        = 32'd0;
        req_valid  = 1'b1;
        req_addr   = a;
        resp_ready = 1'($urandom_range(0, 1));
        set_wr(c, mode, at, wa, wd);
        check("idle_req_ready", 64'(req_ready), 64'd1);
        check("idle_resp_valid", 64'(resp_valid), 64'd0);
        cycle(LAT == 1, a);
        c++;
        exp_req++;
        // Junk on the request bus must not disturb the captured address.
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = {$urandom, $urandom};
        for (int k = 1; k < LAT; k++) begin
            check("busy_resp_valid", 64'(resp_valid), 64'd0);
            check("busy_req_ready", 64'(req_ready), 64'd0);
            set_wr(c, mode, at, wa, wd);
            cycle(k == LAT - 1, a);
            c++;
        end
        for (int s = 0; s <= stall; s++) begin
            check("resp_valid", 64'(resp_valid), 64'd1);
            check("resp_inst", 64'(resp_inst), 64'(exp_inst));
            check("resp_err", 64'(resp_err), 64'(exp_err));
            check("resp_req_ready", 64'(req_ready), 64'd0);
            got        = resp_inst;
            resp_ready = (s == stall);
            req_valid  = 1'($urandom_range(0, 1));
            set_wr(c, mode, at, wa, wd);
            cycle(1'b0, a);
            c++;
        end
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        wr_en      = 1'b0;
        exp_stall += stall;
        check("post_hs_resp_valid", 64'(resp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
`ifdef INST_MEM_PERF_EN
        check("perf_req_cnt", 64'(perf_req_cnt), 64'(exp_req));
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(exp_stall));
`endif
        $display("txn addr=%h stall=%0d inst=%h err=%0d", a, stall, got, resp_err);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        cycle(1'b0, 64'd0);
        reset = 1'b0;
        exp_req   = 0;
        exp_stall = 0;
    endtask

    function automatic logic [63:0] rand_addr();
        int r = int'($urandom_range(0, 11));
        if (r == 0) return BASE - 64'd4;
        if (r == 1) return LIMIT;
        if (r == 2) return BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(1, 3));
        if (r == 3) return LIMIT - 64'd4;
        return BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 1)) * 64'd4;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid = 0; req_addr = 0; resp_ready = 0;
        req_valid1 = 0; req_addr1 = 0; resp_ready1 = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        reset = 1'b1;
        cycle(1'b0, 64'd0);
        cycle(1'b0, 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_inst", 64'(resp_inst), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        reset_pulse();
`ifdef INST_MEM_PERF_EN
        check("rst_perf_req", 64'(perf_req_cnt), 64'd0);
        check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif

        // Preload words 0..15 and the top word.
        for (int i = 0; i <= 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = (i == 16) ? LIMIT - 64'd8 : BASE + 64'(i) * 64'd8;
            wr_data = (i == 0) ? 64'hDEADBEEF_00000013 : {$urandom, $urandom};
            wr_strb = 8'hFF;
            cycle(1'b0, 64'd0);
        end
        wr_en = 1'b0;

        read_txn(BASE, 0, 0, 0, 0, 0, got_inst);
        check("plan_word0_lo", 64'(got_inst), 64'h00000013);
        read_txn(BASE + 64'd4, 0, 0, 0, 0, 0, got_inst);
        check("plan_word0_hi", 64'(got_inst), 64'hDEADBEEF);
        read_txn(BASE + 64'd8, 5, 0, 0, 0, 0, got_inst);

        read_txn(64'h7FFF_FFFC, 1, 0, 0, 0, 0, got_inst);
        read_txn(64'h8000_2000, 0, 0, 0, 0, 0, got_inst);
        read_txn(64'h8000_0002, 0, 0, 0, 0, 0, got_inst);
        read_txn(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, got_inst);
        read_txn(LIMIT - 64'd4, 0, 0, 0, 0, 0, got_inst);

        // Write race on word 1: a write landing before the RESP-entry edge is
        // returned, one landing on that edge is not.
        read_txn(BASE + 64'd8, 0, 2, 0, BASE + 64'd8, 64'h1, got_inst);
        check("race_visible", 64'(got_inst), 64'h1);
        read_txn(BASE + 64'd8, 0, 2, 1, BASE + 64'd8, 64'h2, got_inst);
        check("race_old", 64'(got_inst), 64'h1);
        read_txn(BASE + 64'd8, 0, 0, 0, 0, 0, got_inst);
        check("race_after", 64'(got_inst), 64'h2);

        // Reset one cycle after accept, then reset during RESP.
        for (int m = 0; m < 2; m++) begin
            req_valid = 1'b1;
            req_addr  = BASE;
            cycle(1'b0, 64'd0);
            req_valid = 1'b0;
            if (m == 1) cycle(1'b0, 64'd0);
            reset_pulse();
            for (int k = 0; k < 4; k++) begin
                check("midrst_resp_valid", 64'(resp_valid), 64'd0);
                check("midrst_req_ready", 64'(req_ready), 64'd1);
                cycle(1'b0, 64'd0);
            end
            read_txn(BASE, 0, 0, 0, 0, 0, got_inst);
            check("midrst_preload", 64'(got_inst), 64'h00000013);
        end

        // LATENCY=1 back-to-back with the request held high.
        req_valid1  = 1'b1;
        req_addr1   = BASE + 64'd4;
        resp_ready1 = 1'b1;
        check("l1_idle_ready", 64'(req_ready1), 64'd1);
        for (int n = 0; n < 8; n++) begin
            cycle(1'b0, 64'd0);
            check("l1_resp_valid", 64'(resp_valid1), 64'(n % 2 == 0));
            check("l1_req_ready", 64'(req_ready1), 64'(n % 2 == 1));
            if (n % 2 == 0) begin
                check("l1_resp_inst", 64'(resp_inst1), 64'hDEADBEEF);
                check("l1_resp_err", 64'(resp_err1), 64'd0);
            end
            $display("l1 cycle=%0d valid=%0d ready=%0d inst=%h", n, resp_valid1, req_ready1, resp_inst1);
        end
        req_valid1  = 1'b0;
        resp_ready1 = 1'b0;
`ifdef INST_MEM_PERF_EN
        check("l1_perf_req", 64'(perf_req_cnt1), 64'd4);
        check("l1_perf_stall", 64'(perf_stall_cnt1), 64'd0);
`endif

        // Randomized fetches with background writes.
        for (int t = 0; t < 60; t++) begin
            read_txn(rand_addr(), int'($urandom_range(0, 3)), 1, 0, 0, 0, got_inst);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
